// File: rtl/datatap_pkg.sv
// Shared types and default sizing for the data-tap capture block.
package datatap_pkg;

   localparam int TAP_W_DEF  = 3;
   localparam int TS_W_DEF   = 16;
   localparam int DEPTH_DEF  = 4;
   localparam int DROP_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } datatap_state_e;

   // Record layout at default widths, MSB first: {wrap, lost, tap, ts}.
   typedef struct packed {
      logic                  wrap;
      logic                  lost;
      logic [TAP_W_DEF-1:0]  tap;
      logic [TS_W_DEF-1:0]   ts;
   } datatap_ev_t;

endpackage

// File: rtl/datatap_fifo.sv
// Synchronous FIFO with a registered head word and wrap-bit pointers.
module datatap_fifo #(
   parameter int W     = 21,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] head_q, head_d;
   logic         do_pop, do_push;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign head_o  = head_q;

   // Next pointers and next head; a push into a FIFO that is empty after
   // this cycle's pop lands directly in the head register.
   always_comb begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      head_d   = mem_q[rd_ptr_d[AW-1:0]];
      if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
         head_d = data_i;
   end

   // Storage array; contents need no reset, pointers define validity.
   always_ff @(posedge clk_i) begin
      if (do_push)
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

   // Pointer and head registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/datatap_capture.sv
// Samples the tap vector, timestamps value changes and ts wraps, and
// queues the resulting records for a valid/ready consumer.
module datatap_capture
   import datatap_pkg::*;
#(
   parameter int TAP_W  = TAP_W_DEF,
   parameter int TS_W   = TS_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int DROP_W = DROP_W_DEF
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic [TAP_W-1:0]        tap_in,
   output logic                    ev_valid,
   input  logic                    ev_ready,
   output logic [TAP_W+TS_W+1:0]   ev_data,
   output logic                    overflow,
   output logic [DROP_W-1:0]       drop_cnt
);

   localparam int              EV_W   = TAP_W + TS_W + 2;
   localparam logic [TS_W-1:0] TS_MAX = '1;

   datatap_state_e    state_q, state_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic [TAP_W-1:0]  tap_q, tap_prev_q;
   logic              lost_pend_q, lost_pend_d;
   logic              overflow_q, overflow_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   logic              change, wrapev, push_req, push_ok, drop, pop;
   logic              fifo_full, fifo_empty;
   logic [EV_W-1:0]   ev_rec;

   assign change   = (tap_q != tap_prev_q);
   assign wrapev   = (ts_q == TS_MAX);
   // Leaving RUN because enable dropped yields no record for that cycle.
   assign push_req = (state_q == RUN) && enable && (change || wrapev);
   assign pop      = ev_valid & ev_ready;
   assign push_ok  = push_req & (~fifo_full | pop);
   assign drop     = push_req & fifo_full & ~pop;
   assign ev_rec   = {wrapev, lost_pend_q, tap_q, ts_q};

   assign ev_valid = ~fifo_empty;
   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;

   // Tap sampling pipeline; runs every cycle so the baseline is always fresh.
   always_ff @(posedge clock) begin
      tap_q      <= tap_in;
      tap_prev_q <= tap_q;
   end

   // Capture FSM next state and timestamp; ts is zero whenever in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = PRIME;
         PRIME:   state_d = enable ? RUN : IDLE;
         RUN:     if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ts_d = ts_q;
      if (state_d == IDLE)
         ts_d = '0;
      else if (state_q != IDLE)
         ts_d = ts_q + 1'b1;
   end

   // Drop bookkeeping: sticky overflow, saturating count, lost marker.
   always_comb begin
      lost_pend_d = lost_pend_q;
      overflow_d  = overflow_q;
      drop_cnt_d  = drop_cnt_q;
      if (push_ok)
         lost_pend_d = 1'b0;
      if (drop) begin
         lost_pend_d = 1'b1;
         overflow_d  = 1'b1;
         if (drop_cnt_q != {DROP_W{1'b1}})
            drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   // Control state registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ts_q        <= '0;
         lost_pend_q <= 1'b0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ts_q        <= ts_d;
         lost_pend_q <= lost_pend_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   datatap_fifo #(.W(EV_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset_n),
      .push_i  (push_ok),
      .data_i  (ev_rec),
      .pop_i   (ev_ready),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (ev_data)
   );

endmodule
